div_sequencer: RTL and testbench

- Multi-cycle restoring divider controller for the RV32M DIV/DIVU/REM/REMU path.
- Time-shares one `ripple_carry_adder_subtractor` instance, width SIZE+1, for four jobs: operand negation, per-bit trial subtraction, and quotient/remainder sign fix-up.
- Sits beside the ALU. The execute stage starts it and stalls on `busy`.

---
 rtl/div_pkg.sv | 20 ++
 rtl/ripple_carry_adder_subtractor.sv | 26 ++
 rtl/div_sequencer.sv | 174 +++++++++++++++++
 tb/tb_div_sequencer.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the div_sequencer restoring divider.
package div_pkg;

  localparam int DIV_SIZE = 32;
  localparam int DIV_CNT_W = $clog2(DIV_SIZE);
  localparam logic [DIV_SIZE-1:0] DIV_QUOT_ONES = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_NEG_A,
    S_NEG_B,
    S_ITER,
    S_FIX_Q,
    S_FIX_R,
    S_DONE
  } div_state_t;

  typedef logic [DIV_CNT_W-1:0] div_cnt_t;

endpackage

// File: rtl/ripple_carry_adder_subtractor.sv
// N-bit ripple-carry adder/subtractor: S = A + (B ^ {N{CTRL}}) + CTRL, C = carry out.
module ripple_carry_adder_subtractor #(
  parameter int N = 8
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         CTRL,
  output logic [N-1:0] S,
  output logic         C
);

  // Ripple the carry bit by bit; CTRL inverts B and supplies the +1 for subtraction.
  always_comb begin
    logic cy;
    logic bx;
    cy = CTRL;
    S  = '0;
    for (int i = 0; i < N; i++) begin
      bx   = B[i] ^ CTRL;
      S[i] = A[i] ^ bx ^ cy;
      cy   = (A[i] & bx) | (cy & (A[i] ^ bx));
    end
    C = cy;
  end

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle restoring divider controller for DIV/DIVU/REM/REMU.
// One shared adder/subtractor handles operand negation, trial subtraction
// and sign fix-up. Optional build macro DIV_SEQUENCER_EARLY_OUT_EN finishes
// a divide-by-one in a single cycle instead of walking the full sequence.
module div_sequencer
  import div_pkg::*;
#(
  parameter int SIZE = DIV_SIZE
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            is_signed,
  input  logic [SIZE-1:0] dividend,
  input  logic [SIZE-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [SIZE-1:0] quotient,
  output logic [SIZE-1:0] remainder,
  output logic            div_by_zero
);

  div_state_t      state;
  div_cnt_t        cnt;
  logic [SIZE-1:0] a_reg;
  logic [SIZE-1:0] d_reg;
  logic [SIZE-1:0] r_reg;
  logic            neg_a;
  logic            neg_b;

  logic [SIZE:0]   add_a;
  logic [SIZE:0]   add_b;
  logic            add_ctrl;
  logic [SIZE:0]   sum;
  logic            carry;
  logic            unused_sum_msb;
  logic [SIZE:0]   trial;

  // Partial remainder shifted left with the next dividend bit appended.
  assign trial = {r_reg, a_reg[SIZE-1]};

  // The top sum bit is never needed: every value written back fits in SIZE bits.
  assign unused_sum_msb = sum[SIZE];

  // Steer the shared adder from whichever state owns it this cycle; idle is 0 + 0.
  always_comb begin
    add_a    = '0;
    add_b    = '0;
    add_ctrl = 1'b0;
    case (state)
      S_NEG_A: begin
        add_b    = {1'b0, a_reg};
        add_ctrl = 1'b1;
      end
      S_NEG_B: begin
        add_b    = {1'b0, d_reg};
        add_ctrl = 1'b1;
      end
      S_ITER: begin
        add_a    = trial;
        add_b    = {1'b0, d_reg};
        add_ctrl = 1'b1;
      end
      S_FIX_Q: begin
        if (neg_a ^ neg_b) begin
          add_b    = {1'b0, a_reg};
          add_ctrl = 1'b1;
        end
      end
      S_FIX_R: begin
        if (neg_a) begin
          add_b    = {1'b0, r_reg};
          add_ctrl = 1'b1;
        end
      end
      default: ;
    endcase
  end

  ripple_carry_adder_subtractor #(
    .N(SIZE + 1)
  ) u_addsub (
    .A   (add_a),
    .B   (add_b),
    .CTRL(add_ctrl),
    .S   (sum),
    .C   (carry)
  );

  // Control FSM plus working registers; every output is registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      a_reg       <= '0;
      d_reg       <= '0;
      r_reg       <= '0;
      neg_a       <= 1'b0;
      neg_b       <= 1'b0;
      cnt         <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_reg <= dividend;
            d_reg <= divisor;
            r_reg <= '0;
            neg_a <= is_signed & dividend[SIZE-1];
            neg_b <= is_signed & divisor[SIZE-1];
            if (divisor == '0) begin
              quotient    <= DIV_QUOT_ONES[SIZE-1:0];
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              done        <= 1'b1;
              state       <= S_DONE;
            end
`ifdef DIV_SEQUENCER_EARLY_OUT_EN
            else if (divisor == SIZE'(1)) begin
              quotient    <= dividend;
              remainder   <= '0;
              div_by_zero <= 1'b0;
              done        <= 1'b1;
              state       <= S_DONE;
            end
`endif
            else begin
              div_by_zero <= 1'b0;
              busy        <= 1'b1;
              state       <= S_NEG_A;
            end
          end
        end
        S_NEG_A: begin
          if (neg_a) a_reg <= sum[SIZE-1:0];
          state <= S_NEG_B;
        end
        S_NEG_B: begin
          if (neg_b) d_reg <= sum[SIZE-1:0];
          cnt   <= div_cnt_t'(SIZE - 1);
          state <= S_ITER;
        end
        S_ITER: begin
          if (carry) r_reg <= sum[SIZE-1:0];
          else       r_reg <= trial[SIZE-1:0];
          a_reg <= {a_reg[SIZE-2:0], carry};
          if (cnt == '0) state <= S_FIX_Q;
          else           cnt   <= cnt - 1'b1;
        end
        S_FIX_Q: begin
          if (neg_a ^ neg_b) a_reg <= sum[SIZE-1:0];
          state <= S_FIX_R;
        end
        S_FIX_R: begin
          quotient  <= a_reg;
          remainder <= neg_a ? sum[SIZE-1:0] : r_reg;
          busy      <= 1'b0;
          done      <= 1'b1;
          state     <= S_DONE;
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// Directed self-checking bench for div_sequencer (SIZE = 32).
// Honors DIV_SEQUENCER_EARLY_OUT_EN for the expected divide-by-one latency.
module tb_div_sequencer;

  localparam int SIZE     = 32;
  localparam int LAT_FULL = SIZE + 5;
`ifdef DIV_SEQUENCER_EARLY_OUT_EN
  localparam int LAT_ONE  = 1;
`else
  localparam int LAT_ONE  = LAT_FULL;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic            is_signed;
  logic [SIZE-1:0] dividend;
  logic [SIZE-1:0] divisor;
  logic            busy;
  logic            done;
  logic [SIZE-1:0] quotient;
  logic [SIZE-1:0] remainder;
  logic            div_by_zero;

  int testsRun    = 0;
  int testsFailed = 0;

  div_sequencer #(.SIZE(SIZE)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .is_signed  (is_signed),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Present a one-cycle start; returns #1 after the accepting edge.
  task automatic applyStimulus(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start     = 1'b1;
    is_signed = sgn;
    dividend  = a;
    divisor   = b;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Cycle 1 is the cycle right after the accepting edge; optionally pulses a
  // competing start (50 / 0) in cycle intrCycle.
  task automatic waitDone(input int intrCycle, output int lat, output logic busyBad);
    lat     = 0;
    busyBad = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      if (c > 1) begin
        @(posedge clk);
        #1;
      end
      if (c == intrCycle) begin
        start     = 1'b1;
        is_signed = 1'b1;
        dividend  = 32'd50;
        divisor   = 32'd0;
      end else if (intrCycle > 0 && c == intrCycle + 1) begin
        start = 1'b0;
      end
      if (done === 1'b1) begin
        lat = c;
        break;
      end
      if (busy !== 1'b1) busyBad = 1'b1;
    end
    start = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] expQ, input logic [31:0] expR, input logic expDz,
                             input int expLat, input int intrCycle);
    int   lat;
    logic busyBad;
    applyStimulus(sgn, a, b);
    waitDone(intrCycle, lat, busyBad);
    checkValue({tag, ".latency"}, 32'(lat), 32'(expLat));
    checkValue({tag, ".busyBefore"}, 32'(busyBad), 32'd0);
    checkValue({tag, ".busyAtDone"}, 32'(busy), 32'd0);
    checkValue({tag, ".quotient"}, quotient, expQ);
    checkValue({tag, ".remainder"}, remainder, expR);
    checkValue({tag, ".divByZero"}, 32'(div_by_zero), 32'(expDz));
    @(posedge clk);
    #1;
    checkValue({tag, ".donePulse"}, 32'(done), 32'd0);
  endtask

  // Directed sequence of operations with hand-computed results.
  initial begin
    logic sawDone;
    rst       = 1'b1;
    start     = 1'b0;
    is_signed = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(posedge clk);
    #1;
    checkValue("reset.busy", 32'(busy), 32'd0);
    checkValue("reset.done", 32'(done), 32'd0);
    checkValue("reset.quotient", quotient, 32'd0);
    checkValue("reset.remainder", remainder, 32'd0);
    checkValue("reset.divByZero", 32'(div_by_zero), 32'd0);
    rst = 1'b0;

    checkOutput("udiv100by7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, LAT_FULL, 0);
    checkOutput("sdivNeg7by2", 1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, LAT_FULL, 0);
    checkOutput("sdiv7byNeg2", 1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0000_0001, 1'b0, LAT_FULL, 0);
    checkOutput("udivByZero", 1'b0, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 32'h0000_1234, 1'b1, 1, 0);
    checkOutput("sdivByZero", 1'b1, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 32'h0000_1234, 1'b1, 1, 0);
    checkOutput("udiv5by1", 1'b0, 32'd5, 32'd1, 32'd5, 32'd0, 1'b0, LAT_ONE, 0);
    checkOutput("sdivOverflow", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b0, LAT_FULL, 0);
    checkOutput("udivMaxBy16", 1'b0, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0FFF_FFFF, 32'h0000_000F, 1'b0, LAT_FULL, 0);

    // Abort an operation with reset in cycle 10.
    applyStimulus(1'b0, 32'd1000, 32'd10);
    for (int c = 2; c <= 10; c++) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkValue("abort.busy", 32'(busy), 32'd0);
    checkValue("abort.done", 32'(done), 32'd0);
    checkValue("abort.quotient", quotient, 32'd0);
    checkValue("abort.remainder", remainder, 32'd0);
    sawDone = 1'b0;
    for (int c = 0; c < 45; c++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) sawDone = 1'b1;
    end
    checkValue("abort.noDone", 32'(sawDone), 32'd0);

    checkOutput("udiv9by3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, LAT_FULL, 0);
    checkOutput("udivDeadbeefBy1", 1'b0, 32'hDEAD_BEEF, 32'd1, 32'hDEAD_BEEF, 32'd0, 1'b0, LAT_ONE, 0);
    checkOutput("startWhileBusy", 1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, 1'b0, LAT_FULL, 5);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
